// File: rtl/sdram_pingpong_sched_pkg.sv
// Shared SDRAM burst/buffer defaults and address helpers for the ping-pong burst scheduler.
package sdram_pingpong_sched_pkg;

    localparam int SDRAM_BURST_LEN = 8;
    localparam int SDRAM_BUFF_SIZE = 512;

    // Buffer select bit -> two-bit bank code (buffer 0 = 2'b00, buffer 1 = 2'b10).
    function automatic logic [1:0] bank_code(input logic buf_sel);
        return {buf_sel, 1'b0};
    endfunction

endpackage

// File: rtl/sdram_buf_addr_gen.sv
// Burst offset counter for one ping-pong buffer: steps by BURST_LEN, flags the last burst, holds a bank bit.
module sdram_buf_addr_gen
    import sdram_pingpong_sched_pkg::*;
#(
    parameter int OFF_W     = 20,
    parameter int BURST_LEN = SDRAM_BURST_LEN,
    parameter int BUFF_SIZE = SDRAM_BUFF_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             bank_ld,
    input  logic             bank_d,
    output logic [OFF_W-1:0] off,
    output logic             bank,
    output logic             last
);

    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BUFF_SIZE - BURST_LEN);
    localparam logic [OFF_W-1:0] STEP     = OFF_W'(BURST_LEN);

    assign last = (off == LAST_OFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off  <= '0;
            bank <= 1'b0;
        end else begin
            if (step) begin
                off <= last ? '0 : off + STEP;
            end
            if (bank_ld) begin
                bank <= bank_d;
            end
        end
    end

endmodule

// File: rtl/sdram_pingpong_sched.sv
// Arbitrates burst writes and reads to the SDRAM controller over one or two alternating buffers.
module sdram_pingpong_sched
    import sdram_pingpong_sched_pkg::*;
#(
    parameter int ADDR_W    = 22,
    parameter int USEDW_W   = 11,
    parameter int BURST_LEN = SDRAM_BURST_LEN,
    parameter int BUFF_SIZE = SDRAM_BUFF_SIZE,
    parameter int RD_THRESH = 2 * BURST_LEN,
    parameter int PINGPONG  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ctrl_idle,
    input  logic               cmd_ack,
    input  logic [USEDW_W-1:0] w_fifo_rusedw,
    input  logic [USEDW_W-1:0] r_fifo_wusedw,
    output logic               sys_w_req,
    output logic               sys_r_req,
    output logic [ADDR_W-1:0]  sys_wr_addr,
    output logic               read_en,
    output logic               wr_buf_done,
    output logic               rd_buf_done
);

    localparam int OFF_W = ADDR_W - 2;
    localparam logic [USEDW_W-1:0] RD_TH = USEDW_W'(RD_THRESH);
    localparam logic [USEDW_W-1:0] BL_U  = USEDW_W'(BURST_LEN);

    generate
        if ((BUFF_SIZE % BURST_LEN) != 0 || longint'(BUFF_SIZE) > (longint'(1) << OFF_W)) begin : g_bad_cfg
            $error("sdram_pingpong_sched: BUFF_SIZE must be a multiple of BURST_LEN and fit the offset field");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ} state_t;
    state_t state;

    logic [OFF_W-1:0] wr_off, rd_off;
    logic wr_bank, rd_bank, wr_last, rd_last;
    logic wr_step, rd_step, rd_first, rd_src, rd_cur_bank;
    logic rd_eligible, wr_eligible;

    assign wr_step = (state == WR_REQ) && sys_w_req && cmd_ack;
    assign rd_step = (state == RD_REQ) && sys_r_req && cmd_ack;

    // Reads follow the most recently completed write buffer, chosen only at the start of a pass.
    assign rd_src      = (PINGPONG != 0) ? ~wr_bank : 1'b0;
    assign rd_first    = (rd_off == '0);
    assign rd_cur_bank = (rd_first && read_en) ? rd_src : rd_bank;

    assign rd_eligible = read_en && (r_fifo_wusedw <= RD_TH);
    assign wr_eligible = (w_fifo_rusedw >= BL_U);

    assign sys_wr_addr = sys_w_req ? {bank_code(wr_bank), wr_off}
                                   : {bank_code(rd_cur_bank), rd_off};

    sdram_buf_addr_gen #(
        .OFF_W(OFF_W), .BURST_LEN(BURST_LEN), .BUFF_SIZE(BUFF_SIZE)
    ) u_wr_addr (
        .clk(clk), .rst_n(rst_n), .step(wr_step),
        .bank_ld(wr_step && wr_last && (PINGPONG != 0)), .bank_d(~wr_bank),
        .off(wr_off), .bank(wr_bank), .last(wr_last)
    );

    sdram_buf_addr_gen #(
        .OFF_W(OFF_W), .BURST_LEN(BURST_LEN), .BUFF_SIZE(BUFF_SIZE)
    ) u_rd_addr (
        .clk(clk), .rst_n(rst_n), .step(rd_step),
        .bank_ld(rd_step && rd_first), .bank_d(rd_cur_bank),
        .off(rd_off), .bank(rd_bank), .last(rd_last)
    );

    // Handshake: a request rises the cycle after entering its state and holds until
    // cmd_ack is sampled with it high; the ack edge drops it and returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sys_w_req   <= 1'b0;
            sys_r_req   <= 1'b0;
            read_en     <= 1'b0;
            wr_buf_done <= 1'b0;
            rd_buf_done <= 1'b0;
        end else begin
            wr_buf_done <= 1'b0;
            rd_buf_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl_idle) begin
                        if (rd_eligible) begin
                            state <= RD_REQ;
                        end else if (wr_eligible) begin
                            state <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (wr_step) begin
                        sys_w_req <= 1'b0;
                        state     <= IDLE;
                        if (wr_last) begin
                            wr_buf_done <= 1'b1;
                            read_en     <= 1'b1;
                        end
                    end else begin
                        sys_w_req <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (rd_step) begin
                        sys_r_req <= 1'b0;
                        state     <= IDLE;
                        if (rd_last) begin
                            rd_buf_done <= 1'b1;
                        end
                    end else begin
                        sys_r_req <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_pingpong_sched.sv
// Scoreboard bench: one ping-pong instance and one single-buffer instance, acked 2 cycles after request.
module tb_sdram_pingpong_sched;

    localparam int AW = 22;
    localparam int UW = 11;
    localparam int BL = 8;
    localparam int BS = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ping-pong instance (sel 0)
    logic          ctrl_idle, cmd_ack;
    logic [UW-1:0] w_lvl, r_lvl;
    logic          w_req, r_req, read_en, wdone, rdone;
    logic [AW-1:0] addr;
    // single-buffer instance (sel 1)
    logic          ctrl_idle0, cmd_ack0;
    logic [UW-1:0] w_lvl0, r_lvl0;
    logic          w_req0, r_req0, read_en0, wdone0, rdone0;
    logic [AW-1:0] addr0;

    sdram_pingpong_sched #(
        .ADDR_W(AW), .USEDW_W(UW), .BURST_LEN(BL), .BUFF_SIZE(BS), .RD_THRESH(2*BL), .PINGPONG(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_idle(ctrl_idle), .cmd_ack(cmd_ack),
        .w_fifo_rusedw(w_lvl), .r_fifo_wusedw(r_lvl),
        .sys_w_req(w_req), .sys_r_req(r_req), .sys_wr_addr(addr),
        .read_en(read_en), .wr_buf_done(wdone), .rd_buf_done(rdone)
    );

    sdram_pingpong_sched #(
        .ADDR_W(AW), .USEDW_W(UW), .BURST_LEN(BL), .BUFF_SIZE(BS), .RD_THRESH(2*BL), .PINGPONG(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .ctrl_idle(ctrl_idle0), .cmd_ack(cmd_ack0),
        .w_fifo_rusedw(w_lvl0), .r_fifo_wusedw(r_lvl0),
        .sys_w_req(w_req0), .sys_r_req(r_req0), .sys_wr_addr(addr0),
        .read_en(read_en0), .wr_buf_done(wdone0), .rd_buf_done(rdone0)
    );

    logic [AW:0]   exp_q[$];   // {is_read, address}
    int            n_checks = 0;
    int            n_bad = 0;
    logic [19:0]   m_wr_off[2];
    logic [19:0]   m_rd_off[2];
    logic          m_wr_bank[2];
    logic          m_rd_bank[2];
    logic          m_read_en[2];
    logic          exp_wdone, exp_rdone;
    logic [AW-1:0] last_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_wr_off[s] = '0; m_rd_off[s] = '0;
            m_wr_bank[s] = 1'b0; m_rd_bank[s] = 1'b0; m_read_en[s] = 1'b0;
        end
        exp_q.delete();
    endtask

    // Predict the next request from the current input levels and advance the model as if acked.
    task automatic predict(input int s);
        logic rd, wr, b;
        logic [UW-1:0] wl, rl;
        wl = (s != 0) ? w_lvl0 : w_lvl;
        rl = (s != 0) ? r_lvl0 : r_lvl;
        rd = m_read_en[s] && (rl <= UW'(2*BL));
        wr = (wl >= UW'(BL));
        exp_wdone = 1'b0;
        exp_rdone = 1'b0;
        if (rd) begin
            b = (m_rd_off[s] == 20'd0) ? ((s == 0) ? ~m_wr_bank[s] : 1'b0) : m_rd_bank[s];
            m_rd_bank[s] = b;
            exp_q.push_back({1'b1, b, 1'b0, m_rd_off[s]});
            if (m_rd_off[s] == 20'(BS-BL)) begin
                m_rd_off[s] = '0;
                exp_rdone = 1'b1;
            end else begin
                m_rd_off[s] = m_rd_off[s] + 20'(BL);
            end
        end else if (wr) begin
            exp_q.push_back({1'b0, m_wr_bank[s], 1'b0, m_wr_off[s]});
            if (m_wr_off[s] == 20'(BS-BL)) begin
                m_wr_off[s] = '0;
                if (s == 0) m_wr_bank[s] = ~m_wr_bank[s];
                m_read_en[s] = 1'b1;
                exp_wdone = 1'b1;
            end else begin
                m_wr_off[s] = m_wr_off[s] + 20'(BL);
            end
        end
    endtask

    task automatic wait_req(input int s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((s != 0) ? (w_req0 | r_req0) : (w_req | r_req)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic serve(input int s);
        bit ok;
        logic [AW:0] got, e;
        predict(s);
        wait_req(s, ok);
        if (!ok) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            return;
        end
        got = (s != 0) ? {r_req0, addr0} : {r_req, addr};
        check("both_req", 32'((s != 0) ? (w_req0 & r_req0) : (w_req & r_req)), 32'd0);
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("req_addr", 32'(got), 32'(e));
        end
        last_addr = got[AW-1:0];
        @(negedge clk);
        if (s != 0) cmd_ack0 = 1'b1; else cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack0 = 1'b0;
        cmd_ack = 1'b0;
        check("req_drop", 32'((s != 0) ? (w_req0 | r_req0) : (w_req | r_req)), 32'd0);
        check("wr_done", 32'((s != 0) ? wdone0 : wdone), 32'(exp_wdone));
        check("rd_done", 32'((s != 0) ? rdone0 : rdone), 32'(exp_rdone));
        check("read_en", 32'((s != 0) ? read_en0 : read_en), 32'(m_read_en[s]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] wr_tab[5];
        logic [AW-1:0] pp0_tab[5];
        logic any_req;
        bit ok;
        wr_tab  = '{22'h000000, 22'h000008, 22'h000010, 22'h000018, 22'h200000};
        pp0_tab = '{22'h000000, 22'h000008, 22'h000010, 22'h000018, 22'h000000};
        ctrl_idle = 0; cmd_ack = 0; w_lvl = 0; r_lvl = 0;
        ctrl_idle0 = 0; cmd_ack0 = 0; w_lvl0 = 0; r_lvl0 = 0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_w_req", 32'(w_req), 32'd0);
        check("rst_r_req", 32'(r_req), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_read_en", 32'(read_en), 32'd0);
        check("rst_done", 32'({wdone, rdone}), 32'd0);

        // release with a write already eligible: first request not before the second edge
        rst_n = 1'b1; ctrl_idle = 1; w_lvl = 8; r_lvl = 100;
        @(negedge clk);
        check("early_req", 32'(w_req | r_req), 32'd0);
        for (int i = 0; i < 5; i++) begin
            serve(0);
            check("wr_tab", 32'(last_addr), 32'(wr_tab[i]));
            if (i == 3) check("read_en_set", 32'(read_en), 32'd1);
        end

        // read and write both eligible: read wins
        r_lvl = 16;
        serve(0);
        check("rd_first_addr", 32'(last_addr), 32'h000000);
        w_lvl = 0;
        serve(0);
        // write buffer 1 completes while the read pass sits at offset 0x10
        w_lvl = 8; r_lvl = 100;
        for (int i = 0; i < 3; i++) serve(0);
        check("wr_wrap_addr", 32'(last_addr), 32'h200018);
        w_lvl = 0; r_lvl = 16;
        serve(0);
        check("rd_mid_bank0", 32'(last_addr), 32'h000010);
        serve(0);
        check("rd_end_bank0", 32'(last_addr), 32'h000018);
        serve(0);
        ctrl_idle = 0; w_lvl = 8;
        check("rd_new_pass", 32'(last_addr), 32'h200000);

        // controller busy: nothing issued, stray ack ignored
        any_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_ack = (i == 2);
            @(negedge clk);
            any_req = any_req | w_req | r_req;
        end
        cmd_ack = 0;
        check("busy_no_req", 32'(any_req), 32'd0);
        check("idle_ack_addr", 32'(addr), 32'h200008);
        ctrl_idle = 1;
        serve(0);
        check("rd_after_busy", 32'(last_addr), 32'h200008);

        // reset while a write request is pending
        r_lvl = 100;
        wait_req(0, ok);
        #2 rst_n = 1'b0;
        #1;
        check("arst_w_req", 32'(w_req | r_req), 32'd0);
        check("arst_addr", 32'(addr), 32'd0);
        check("arst_flags", 32'({read_en, wdone, rdone}), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        serve(0);
        check("wr_after_rst", 32'(last_addr), 32'h000000);
        ctrl_idle = 0;

        // single-buffer instance: everything stays in bank 0
        ctrl_idle0 = 1; w_lvl0 = 8; r_lvl0 = 100;
        for (int i = 0; i < 5; i++) begin
            serve(1);
            check("pp0_wr", 32'(last_addr), 32'(pp0_tab[i]));
        end
        w_lvl0 = 0; r_lvl0 = 16;
        for (int i = 0; i < 5; i++) begin
            serve(1);
            check("pp0_rd", 32'(last_addr), 32'(pp0_tab[i]));
        end
        ctrl_idle0 = 0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
